a2d_resp: RTL and testbench

SPI responder for the eight-channel A2D link: the target end of the SS_n/SCLK/MOSI/MISO bus driven by the A2D SPI initiator. It decodes a 16-bit command frame to select a channel. It returns that channel's 12-bit sample in the following frame. The parent supplies channel data through a select/value pair, so the block can sit behind a real sensor mux or a bench model.

---
 rtl/a2d_resp.sv | 173 +++++++++++++++++
 tb/tb_a2d_resp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_resp.sv
// SPI responder for the eight-channel A2D link: decodes a 16-bit command
// frame into a channel select and returns that channel's sample in the
// following frame.
module a2d_resp #(
  parameter logic [3:0]       RESP_PAD = 4'h0,
  localparam int unsigned     VAL_W    = 12,
  localparam int unsigned     SEL_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [VAL_W-1:0] ch_val,
  output logic [SEL_W-1:0] ch_sel,
  output logic             cmd_vld,
  output logic             frm_err
);

  localparam int unsigned FRM_W  = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned RX_W   = 14;
  localparam int unsigned ARM_W  = 2;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // [0],[1] synchronize; [2] is the previous synced value for edge detection
  logic [2:0]         r_ss_sync;
  logic [2:0]         r_sclk_sync;
  logic [1:0]         r_mosi_sync;
  logic [ARM_W-1:0]   r_arm_cnt;

  // Only bits up to 13 ever reach the channel decode, so the top of the
  // shifter is not kept.
  logic [RX_W-1:0]    r_rx_shft;
  logic [FRM_W-1:0]   r_tx_shft;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [SEL_W-1:0]   r_ch_sel;
  logic               r_cmd_vld;
  logic               r_frm_err;

  logic               w_ss_fall;
  logic               w_ss_rise;
  logic               w_sclk_rise;
  logic               w_sclk_fall;
  logic               w_load;
  logic               w_rx_shift;
  logic               w_tx_shift;
  logic               w_end_good;
  logic               w_end_bad;

  assign w_ss_fall   = ~r_ss_sync[1]   &  r_ss_sync[2];
  assign w_ss_rise   =  r_ss_sync[1]   & ~r_ss_sync[2];
  assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];

  // Bring the SPI pins into the clk domain; idle-high reset avoids false edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_sync   <= 3'b111;
      r_sclk_sync <= 3'b111;
      r_mosi_sync <= 2'b11;
    end else begin
      r_ss_sync   <= {r_ss_sync[1:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  // Count clocks after reset until the synchronizer holds only real pin values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm_cnt <= '0;
    end else if (r_state == ST_ARM && r_arm_cnt != ARM_W'(3)) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; frame end takes priority over SCLK edges
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_shift  = 1'b0;
    w_end_good  = 1'b0;
    w_end_bad   = 1'b0;
    case (r_state)
      ST_ARM: begin
        // Leave only once SS_n is settled high, so a frame in flight is skipped
        if (r_arm_cnt == ARM_W'(3) && r_ss_sync[1] && r_ss_sync[2]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          if (r_bit_cnt == CNT_W'(FRM_W)) begin
            w_end_good = 1'b1;
          end else begin
            w_end_bad  = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end else begin
          w_rx_shift = w_sclk_rise;
          // The leading fall of a frame precedes any rise and must not shift
          w_tx_shift = w_sclk_fall && (r_bit_cnt != '0);
        end
      end
      default: begin
        w_state_nxt = ST_ARM;
      end
    endcase
  end

  // Shift registers, bit counter, channel latch and frame-end pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_shft <= '0;
      r_tx_shft <= '0;
      r_bit_cnt <= '0;
      r_ch_sel  <= '0;
      r_cmd_vld <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_shft <= {RESP_PAD, ch_val};
        r_bit_cnt <= '0;
      end
      if (w_rx_shift) begin
        r_rx_shft <= {r_rx_shft[RX_W-2:0], r_mosi_sync[1]};
        if (r_bit_cnt != CNT_W'(31)) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
      if (w_tx_shift) begin
        r_tx_shft <= {r_tx_shft[FRM_W-2:0], 1'b0};
      end
      if (w_end_good) begin
        r_ch_sel <= r_rx_shft[13:11];
      end
      r_cmd_vld <= w_end_good;
      r_frm_err <= w_end_bad;
    end
  end

  assign MISO    = (r_state == ST_SHIFT) & r_tx_shft[FRM_W-1];
  assign ch_sel  = r_ch_sel;
  assign cmd_vld = r_cmd_vld;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_a2d_resp.sv
// Bench for a2d_resp: directed vector table, a reset-in-frame sequence and
// randomized frames against a frame-level model. A second instance with
// RESP_PAD=4'hF and ch_val tied to zero rides on the same SPI stimulus.
module tb_a2d_resp;

  localparam int unsigned PH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO, MISO_f;
  logic [11:0] ch_val;
  logic [2:0]  ch_sel, ch_sel_f;
  logic        cmd_vld, frm_err, cmd_vld_f, frm_err_f;
  logic [11:0] val_tbl [8];

  int checks = 0;
  int errors = 0;
  int n_vld, n_err, n_both;
  int n_vld_f, n_err_f;

  assign ch_val = val_tbl[ch_sel];

  always #5 clk = ~clk;

  a2d_resp #(.RESP_PAD(4'h0)) u_dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_val(ch_val), .ch_sel(ch_sel), .cmd_vld(cmd_vld), .frm_err(frm_err)
  );

  a2d_resp #(.RESP_PAD(4'hF)) u_dut_f (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO_f),
    .ch_val(12'h000), .ch_sel(ch_sel_f), .cmd_vld(cmd_vld_f), .frm_err(frm_err_f)
  );

  // Count pulse cycles on the non-active edge
  always @(negedge clk) begin
    if (cmd_vld)             n_vld++;
    if (frm_err)             n_err++;
    if (cmd_vld && frm_err)  n_both++;
    if (cmd_vld_f)           n_vld_f++;
    if (frm_err_f)           n_err_f++;
  end

  typedef struct {
    logic [15:0] cmd;
    int          n;
    logic [11:0] v3;
    logic        chk_resp;
    logic [15:0] resp;
    logic [2:0]  sel;
    int          vld;
    int          err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_vec(input logic [15:0] cmd, input int n, input logic [11:0] v3,
                         input logic chk_resp, input logic [15:0] resp,
                         input logic [2:0] sel, input int vld, input int err);
    vec_t v;
    v.cmd = cmd; v.n = n; v.v3 = v3; v.chk_resp = chk_resp; v.resp = resp;
    v.sel = sel; v.vld = vld; v.err = err;
    vt.push_back(v);
  endtask

  // One SPI frame with n SCLK rises; MOSI changes on falls, MISO read on rises
  task automatic do_frame(input logic [15:0] cmd, input int n,
                          output logic [15:0] resp, output logic [15:0] resp_f);
    resp = '0; resp_f = '0;
    n_vld = 0; n_err = 0; n_both = 0; n_vld_f = 0; n_err_f = 0;
    SS_n = 1'b0;
    wait_clk(PH);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      wait_clk(PH);
      SCLK = 1'b1;
      if (i < 16) begin
        resp[15-i]   = MISO;
        resp_f[15-i] = MISO_f;
      end
      wait_clk(PH);
    end
    SS_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] cmd, input int n,
                           input logic chk_resp, input logic [15:0] exp_resp,
                           input logic [2:0] exp_sel, input int exp_vld, input int exp_err);
    logic [15:0] r, rf;
    do_frame(cmd, n, r, rf);
    if (chk_resp) begin
      chk({tag, " resp"}, 32'(r), 32'(exp_resp));
      chk({tag, " resp_pad"}, 32'(rf), 32'h0000_F000);
    end
    chk({tag, " ch_sel"},  32'(ch_sel),  32'(exp_sel));
    chk({tag, " ch_sel_pad"}, 32'(ch_sel_f), 32'(exp_sel));
    chk({tag, " cmd_vld"}, 32'(n_vld),   32'(exp_vld));
    chk({tag, " frm_err"}, 32'(n_err),   32'(exp_err));
    chk({tag, " pad_pulses"}, 32'(n_vld_f + n_err_f), 32'(exp_vld + exp_err));
    chk({tag, " both_high"}, 32'(n_both), 32'h0);
    chk({tag, " miso_idle"}, 32'({MISO, MISO_f}), 32'h0);
  endtask

  initial begin
    logic [2:0]  m_sel;
    logic [15:0] rcmd;
    int          rn;
    logic        miso_seen;

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    for (int i = 0; i < 8; i++) val_tbl[i] = 12'(i * 'h111);
    wait_clk(3);
    chk("reset miso",    32'({MISO, MISO_f}), 32'h0);
    chk("reset ch_sel",  32'(ch_sel),  32'h0);
    chk("reset pulses",  32'({cmd_vld, frm_err, cmd_vld_f, frm_err_f}), 32'h0);
    rst = 1'b0;
    wait_clk(8);

    // Directed vectors: channel 3 command and read, sweep, aborted and long frames
    add_vec(16'h1800, 16, 12'hABC, 1'b1, 16'h0000, 3'd3, 1, 0);
    add_vec(16'h1800, 16, 12'hABC, 1'b1, 16'h0ABC, 3'd3, 1, 0);
    for (int c = 0; c < 8; c++) begin
      int prev;
      prev = (c == 0) ? 3 : c - 1;
      add_vec(16'(c << 11), 16, 12'h333, 1'b1, 16'(prev * 'h111), 3'(c), 1, 0);
      add_vec(16'(c << 11), 16, 12'h333, 1'b1, 16'(c * 'h111),    3'(c), 1, 0);
    end
    add_vec(16'h2800,  9, 12'h333, 1'b0, 16'h0000, 3'd7, 0, 1);
    add_vec(16'h2800, 16, 12'h333, 1'b1, 16'h0777, 3'd5, 1, 0);
    add_vec(16'h0800, 17, 12'h333, 1'b1, 16'h0555, 3'd5, 0, 1);
    add_vec(16'h2800, 16, 12'h333, 1'b1, 16'h0555, 3'd5, 1, 0);

    for (int k = 0; k < vt.size(); k++) begin
      val_tbl[3] = vt[k].v3;
      wait_clk(4);
      run_frame($sformatf("vec%0d", k), vt[k].cmd, vt[k].n, vt[k].chk_resp,
                vt[k].resp, vt[k].sel, vt[k].vld, vt[k].err);
    end

    // Reset after six rises of a frame; the rest of that frame must be ignored
    rcmd = 16'h3800;
    n_vld = 0; n_err = 0; n_vld_f = 0; n_err_f = 0;
    SS_n = 1'b0;
    wait_clk(PH);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0; MOSI = rcmd[15-i]; wait_clk(PH);
      SCLK = 1'b1; wait_clk(PH);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid miso",   32'({MISO, MISO_f}), 32'h0);
    chk("rst_mid ch_sel", 32'(ch_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    miso_seen = 1'b0;
    for (int i = 6; i < 16; i++) begin
      SCLK = 1'b0; MOSI = rcmd[15-i]; wait_clk(PH);
      SCLK = 1'b1; miso_seen |= MISO | MISO_f; wait_clk(PH);
    end
    SS_n = 1'b1;
    wait_clk(12);
    chk("rst_mid miso_quiet", 32'(miso_seen), 32'h0);
    chk("rst_mid pulses", 32'(n_vld + n_err + n_vld_f + n_err_f), 32'h0);
    chk("rst_mid ch_sel_hold", 32'(ch_sel), 32'h0);
    wait_clk(8);
    run_frame("post_rst", 16'h3000, 16, 1'b1, 16'h0000, 3'd6, 1, 0);
    m_sel = 3'd6;

    // Random frames against a frame-level model
    for (int i = 0; i < 8; i++) val_tbl[i] = 12'($urandom);
    wait_clk(6);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] exp_resp;
      logic [2:0]  exp_sel;
      int          good;
      rcmd = 16'($urandom);
      rn   = ($urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(0, 20));
      exp_resp = {4'h0, val_tbl[m_sel]};
      good     = (rn == 16) ? 1 : 0;
      exp_sel  = good ? rcmd[13:11] : m_sel;
      run_frame($sformatf("rnd%0d", k), rcmd, rn, (rn >= 16), exp_resp, exp_sel,
                good, 1 - good);
      m_sel = exp_sel;
      wait_clk(int'($urandom_range(3, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
